idelay_tap_loader: RTL and testbench
====================================

Name: idelay_tap_loader

Overview:
- Consumer of the IDELAYCTRL ready signal. Drives one IDELAYE2 instance configured as VAR_LOAD, through its LD/CE/INC/CNTVALUEIN pins.
- Waits for calibration ready, then accepts tap-set, increment and decrement requests over a valid/ready handshake.
- Reads back CNTVALUEOUT after each operation and reports done or error.
- Sits between the delay calibration logic and the per-pin IDELAY sweep/test logic in the delay minitests.

Parameters:
- SETTLE_CYCLES, 4, cycles to wait after an LD/CE pulse before sampling CNTVALUEOUT; legal range 1..15.
- INIT_TAP, 0, 5-bit tap value loaded automatically when rdy first rises.

Ports:
- clk  input  1  IDELAYE2 C clock; all logic is in this domain.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  IDELAYCTRL ready, already synchronised to clk.
- req_valid  input  1  request present.
- req_op  input  2  operation code: 00 load, 01 increment, 10 decrement, 11 reserved.
- req_tap  input  5  target tap; used only when req_op is load.
- req_ready  output  1  block can accept a request this cycle.
- idly_ld  output  1  to IDELAYE2 LD.
- idly_ce  output  1  to IDELAYE2 CE.
- idly_inc  output  1  to IDELAYE2 INC.
- idly_cntvaluein  output  5  to IDELAYE2 CNTVALUEIN.
- idly_cntvalueout  input  5  from IDELAYE2 CNTVALUEOUT.
- cur_tap  output  5  last verified tap value.
- done  output  1  one-cycle pulse when an operation completes.
- err  output  1  one-cycle pulse on failure; can coincide with done.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - All outputs are 0, except cur_tap, which resets to INIT_TAP.
  - State resets to WAIT_RDY and the settle counter to 0.
- States: WAIT_RDY, INIT, IDLE, PULSE, SETTLE, CHECK.
- WAIT_RDY:
  - req_ready is 0.
  - When rdy=1 is sampled, go to INIT.
- INIT:
  - Drive idly_ld=1 and idly_cntvaluein=INIT_TAP for exactly 1 cycle. Expected tap = INIT_TAP.
  - Go to SETTLE.
- IDLE:
  - req_ready=1. A transfer occurs when req_valid and req_ready are both 1.
  - On transfer, latch req_op and req_tap, then go to PULSE.
- Load: in PULSE, drive idly_ld=1 and idly_cntvaluein=the latched tap for 1 cycle. Expected tap = the latched tap.
- Increment:
  - If cur_tap=31, make no pin activity. Pulse done and err together in the cycle after acceptance, then return to IDLE. No wrap.
  - Otherwise, drive idly_ce=1 and idly_inc=1 for 1 cycle. Expected tap = cur_tap+1.
- Decrement:
  - If cur_tap=0, reject the same way as increment at 31.
  - Otherwise, drive idly_ce=1 and idly_inc=0 for 1 cycle. Expected tap = cur_tap-1.
- Reserved op 11: pulse done and err together in the cycle after acceptance, with no pin activity, then return to IDLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK:
  - Compare idly_cntvalueout with the expected tap.
  - Match: cur_tap becomes the expected tap and done pulses.
  - Mismatch: cur_tap becomes idly_cntvalueout, and done and err pulse together.
  - Go to IDLE; req_ready is 1 on the next cycle.
  - The CHECK that follows INIT does not pulse done. It pulses err only on a mismatch.
- Latency: request accepted at cycle 0, LD/CE pulse at cycle 1, done at cycle 2+SETTLE_CYCLES.
- Pin quiescence: idly_ld, idly_ce and idly_inc are 0 in every state except INIT and PULSE. Only one of LD or CE is active in any cycle.
- Ready loss: if rdy=0 is sampled in any state other than WAIT_RDY:
  - Abort the current operation and pulse err with no done.
  - Go to WAIT_RDY; cur_tap keeps its value.
  - When rdy returns, INIT runs again.
- Reset mid-operation: rst overrides everything in the same clock edge. Any LD/CE pulse in progress is dropped.
- A request held valid while req_ready=0 is not lost. It is accepted on the first IDLE cycle.

Test Plan:
- Startup: rst for 3 cycles with rdy=0, then rdy=1 at cycle 10 and the model returns the written value -> one idly_ld pulse with cntvaluein=0, no done, req_ready=1 at cycle 12+SETTLE_CYCLES.
- Load: req_op=00, req_tap=17; model echoes the tap -> idly_ld high exactly at accept+1, done at accept+6 with SETTLE_CYCLES=4, cur_tap=17, err=0.
- Increment from 30 twice -> first: CE=1, INC=1, cur_tap=31, done. Second: no CE, done and err in the cycle after accept, cur_tap stays 31.
- Decrement from 0 -> done and err, no CE. Then load 5 and decrement -> CE=1, INC=0, cur_tap=4.
- Readback mismatch: load 9 with the model returning 8 -> done and err together, cur_tap=8.
- rdy drops during SETTLE of a load -> err without done, busy stays high, req_ready=0. When rdy returns, an LD with INIT_TAP is issued, then IDLE.

Source files
------------

// File: rtl/idelay_tap_loader.sv
// idelay_tap_loader: drives one VAR_LOAD IDELAYE2 through LD/CE/INC/CNTVALUEIN.
// Waits for IDELAYCTRL ready, loads INIT_TAP, then serves load/inc/dec
// requests and verifies each one by reading CNTVALUEOUT back after a settle time.
module idelay_tap_loader #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [4:0]  INIT_TAP      = 5'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [4:0] req_tap,
    output logic       req_ready,
    output logic       idly_ld,
    output logic       idly_ce,
    output logic       idly_inc,
    output logic [4:0] idly_cntvaluein,
    input  logic [4:0] idly_cntvalueout,
    output logic [4:0] cur_tap,
    output logic       done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_INIT,
        S_IDLE,
        S_PULSE,
        S_SETTLE,
        S_CHECK
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [4:0] tap_q, tap_d;
    logic [4:0] exp_q, exp_d;
    logic [4:0] cur_tap_q, cur_tap_d;
    logic       init_q, init_d;   // current verify pass follows INIT: no done

    assign cur_tap = cur_tap_q;

    // Next-state, datapath updates and pin/handshake outputs.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        op_d            = op_q;
        tap_d           = tap_q;
        exp_d           = exp_q;
        cur_tap_d       = cur_tap_q;
        init_d          = init_q;
        req_ready       = 1'b0;
        idly_ld         = 1'b0;
        idly_ce         = 1'b0;
        idly_inc        = 1'b0;
        idly_cntvaluein = 5'd0;
        done            = 1'b0;
        err             = 1'b0;
        // Held low while in reset so every output reads 0 during reset.
        busy            = (state_q != S_IDLE) && !rst;

        if (state_q == S_WAIT_RDY) begin
            if (rdy) state_d = S_INIT;
        end else if (!rdy) begin
            // Ready lost: abandon whatever is in flight, keep cur_tap.
            err     = 1'b1;
            cnt_d   = 4'd0;
            state_d = S_WAIT_RDY;
        end else begin
            case (state_q)
                S_INIT: begin
                    idly_ld         = 1'b1;
                    idly_cntvaluein = INIT_TAP;
                    exp_d           = INIT_TAP;
                    init_d          = 1'b1;
                    cnt_d           = 4'd0;
                    state_d         = S_SETTLE;
                end
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        op_d    = req_op;
                        tap_d   = req_tap;
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    init_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_SETTLE;
                    case (op_q)
                        OP_LOAD: begin
                            idly_ld         = 1'b1;
                            idly_cntvaluein = tap_q;
                            exp_d           = tap_q;
                        end
                        OP_INC: begin
                            if (cur_tap_q == 5'd31) begin
                                done    = 1'b1;
                                err     = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                idly_ce  = 1'b1;
                                idly_inc = 1'b1;
                                exp_d    = cur_tap_q + 5'd1;
                            end
                        end
                        OP_DEC: begin
                            if (cur_tap_q == 5'd0) begin
                                done    = 1'b1;
                                err     = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                idly_ce = 1'b1;
                                exp_d   = cur_tap_q - 5'd1;
                            end
                        end
                        default: begin
                            done    = 1'b1;
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    done    = !init_q;
                    state_d = S_IDLE;
                    if (idly_cntvalueout == exp_q) begin
                        cur_tap_d = exp_q;
                    end else begin
                        cur_tap_d = idly_cntvalueout;
                        err       = 1'b1;
                    end
                end
                default: state_d = S_WAIT_RDY;
            endcase
        end
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT_RDY;
            cnt_q     <= 4'd0;
            op_q      <= 2'b00;
            tap_q     <= 5'd0;
            exp_q     <= INIT_TAP;
            cur_tap_q <= INIT_TAP;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tap_q     <= tap_d;
            exp_q     <= exp_d;
            cur_tap_q <= cur_tap_d;
            init_q    <= init_d;
        end
    end

endmodule

// File: tb/tb_idelay_tap_loader.sv
// Directed bench for idelay_tap_loader with a behavioural IDELAYE2 tap model.
module tb_idelay_tap_loader;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, rdy, req_valid;
    logic [1:0] req_op;
    logic [4:0] req_tap;
    logic       req_ready, idly_ld, idly_ce, idly_inc, done, err, busy;
    logic [4:0] idly_cntvaluein, idly_cntvalueout, cur_tap;

    int errors = 0;
    int checks = 0;

    // IDELAYE2 model: LD loads, CE steps; readback can be overridden.
    logic [4:0] model_tap = 5'd0;
    logic       force_en  = 1'b0;
    logic [4:0] force_val = 5'd0;
    assign idly_cntvalueout = force_en ? force_val : model_tap;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (idly_ld)      model_tap <= idly_cntvaluein;
        else if (idly_ce) model_tap <= idly_inc ? model_tap + 5'd1 : model_tap - 5'd1;
    end

    idelay_tap_loader #(.SETTLE_CYCLES(S), .INIT_TAP(5'd0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid(req_valid), .req_op(req_op), .req_tap(req_tap), .req_ready(req_ready),
        .idly_ld(idly_ld), .idly_ce(idly_ce), .idly_inc(idly_inc),
        .idly_cntvaluein(idly_cntvaluein), .idly_cntvalueout(idly_cntvalueout),
        .cur_tap(cur_tap), .done(done), .err(err), .busy(busy)
    );

    // Observations from the last run_op, cycle 1 = first cycle after accept.
    int         ld_at, ce_at, inc_val, done_at, err_at, ld_cnt, ce_cnt;
    logic [4:0] ld_val;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one request and record pin/status activity until done or err.
    task automatic run_op(input logic [1:0] op, input logic [4:0] tap);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL ready_timeout: req_ready=%0b want 1", req_ready); end
        req_valid = 1'b1; req_op = op; req_tap = tap;
        tick();
        req_valid = 1'b0;
        ld_at = -1; ce_at = -1; inc_val = -1; done_at = -1; err_at = -1;
        ld_cnt = 0; ce_cnt = 0; ld_val = 5'd0;
        for (int c = 1; c <= 30; c++) begin
            #1;
            if (idly_ld) begin ld_cnt++; if (ld_at < 0) begin ld_at = c; ld_val = idly_cntvaluein; end end
            if (idly_ce) begin ce_cnt++; if (ce_at < 0) begin ce_at = c; inc_val = int'(idly_inc); end end
            if (done && done_at < 0) done_at = c;
            if (err && err_at < 0) err_at = c;
            if (done || err) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_tap = 5'd0;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if ({req_ready, idly_ld, idly_ce, idly_inc, done, err} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 000000", {req_ready, idly_ld, idly_ce, idly_inc, done, err}); end
        checks++; if (cur_tap !== 5'd0) begin errors++; $display("FAIL reset_cur_tap: got %0d want 0", cur_tap); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL wait_rdy_state: busy=%0b req_ready=%0b want 1/0", busy, req_ready); end
    endtask

    task automatic test_startup();
        int n, lds, dones;
        lds = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (idly_ld) lds++; end
        checks++; if (lds !== 0) begin errors++; $display("FAIL startup_quiet: ld pulses=%0d want 0", lds); end
        rdy = 1'b1;
        tick();
        checks++; if (idly_ld !== 1'b1 || idly_cntvaluein !== 5'd0) begin
            errors++; $display("FAIL init_ld: ld=%0b val=%0d want 1/0", idly_ld, idly_cntvaluein); end
        n = 0; lds = 0; dones = 0;
        while (!req_ready && n < 30) begin
            tick(); n++;
            if (idly_ld) lds++;
            if (done) dones++;
        end
        checks++; if (n !== S + 2) begin errors++; $display("FAIL init_ready_latency: got %0d want %0d", n, S + 2); end
        checks++; if (dones !== 0 || lds !== 0) begin
            errors++; $display("FAIL init_no_done: done=%0d extra_ld=%0d want 0/0", dones, lds); end
    endtask

    task automatic test_load();
        run_op(2'b00, 5'd17);
        checks++; if (ld_at !== 1 || ld_val !== 5'd17 || ld_cnt !== 1 || ce_cnt !== 0) begin
            errors++; $display("FAIL load_pins: ld_at=%0d val=%0d ld_cnt=%0d ce_cnt=%0d want 1/17/1/0", ld_at, ld_val, ld_cnt, ce_cnt); end
        checks++; if (done_at !== S + 2 || err_at !== -1) begin
            errors++; $display("FAIL load_done: done_at=%0d err_at=%0d want %0d/-1", done_at, err_at, S + 2); end
        tick();
        checks++; if (cur_tap !== 5'd17 || req_ready !== 1'b1) begin
            errors++; $display("FAIL load_cur_tap: got %0d ready=%0b want 17/1", cur_tap, req_ready); end
    endtask

    task automatic test_inc_sat();
        run_op(2'b00, 5'd30); tick();
        run_op(2'b01, 5'd0);
        checks++; if (ce_at !== 1 || inc_val !== 1 || ld_cnt !== 0 || done_at !== S + 2 || err_at !== -1) begin
            errors++; $display("FAIL inc_pins: ce_at=%0d inc=%0d ld=%0d done_at=%0d err_at=%0d want 1/1/0/%0d/-1",
                               ce_at, inc_val, ld_cnt, done_at, err_at, S + 2); end
        tick();
        checks++; if (cur_tap !== 5'd31) begin errors++; $display("FAIL inc_cur_tap: got %0d want 31", cur_tap); end
        run_op(2'b01, 5'd0);
        checks++; if (done_at !== 1 || err_at !== 1 || ce_cnt !== 0 || ld_cnt !== 0) begin
            errors++; $display("FAIL inc_sat_reject: done_at=%0d err_at=%0d ce=%0d ld=%0d want 1/1/0/0", done_at, err_at, ce_cnt, ld_cnt); end
        tick();
        checks++; if (cur_tap !== 5'd31 || req_ready !== 1'b1) begin
            errors++; $display("FAIL inc_sat_tap: got %0d ready=%0b want 31/1", cur_tap, req_ready); end
    endtask

    task automatic test_dec();
        run_op(2'b00, 5'd0); tick();
        run_op(2'b10, 5'd0);
        checks++; if (done_at !== 1 || err_at !== 1 || ce_cnt !== 0 || ld_cnt !== 0) begin
            errors++; $display("FAIL dec_zero_reject: done_at=%0d err_at=%0d ce=%0d ld=%0d want 1/1/0/0", done_at, err_at, ce_cnt, ld_cnt); end
        tick();
        checks++; if (cur_tap !== 5'd0) begin errors++; $display("FAIL dec_zero_tap: got %0d want 0", cur_tap); end
        run_op(2'b00, 5'd5); tick();
        run_op(2'b10, 5'd0);
        checks++; if (ce_at !== 1 || inc_val !== 0 || done_at !== S + 2 || err_at !== -1) begin
            errors++; $display("FAIL dec_pins: ce_at=%0d inc=%0d done_at=%0d err_at=%0d want 1/0/%0d/-1", ce_at, inc_val, done_at, err_at, S + 2); end
        tick();
        checks++; if (cur_tap !== 5'd4) begin errors++; $display("FAIL dec_cur_tap: got %0d want 4", cur_tap); end
    endtask

    task automatic test_reserved();
        run_op(2'b11, 5'd9);
        checks++; if (done_at !== 1 || err_at !== 1 || ce_cnt !== 0 || ld_cnt !== 0) begin
            errors++; $display("FAIL reserved_op: done_at=%0d err_at=%0d ce=%0d ld=%0d want 1/1/0/0", done_at, err_at, ce_cnt, ld_cnt); end
        tick();
        checks++; if (cur_tap !== 5'd4) begin errors++; $display("FAIL reserved_tap: got %0d want 4", cur_tap); end
    endtask

    task automatic test_mismatch();
        force_en = 1'b1; force_val = 5'd8;
        run_op(2'b00, 5'd9);
        checks++; if (done_at !== S + 2 || err_at !== S + 2) begin
            errors++; $display("FAIL mismatch_flags: done_at=%0d err_at=%0d want %0d/%0d", done_at, err_at, S + 2, S + 2); end
        tick();
        force_en = 1'b0;
        checks++; if (cur_tap !== 5'd8) begin errors++; $display("FAIL mismatch_tap: got %0d want 8", cur_tap); end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(2'b00, 5'd12);
        req_valid = 1'b1; req_op = 2'b00; req_tap = 5'd20;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL held_not_ready: got %0b want 0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL held_ready: got %0b want 1", req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (idly_ld !== 1'b1 || idly_cntvaluein !== 5'd20) begin
            errors++; $display("FAIL held_accept: ld=%0b val=%0d want 1/20", idly_ld, idly_cntvaluein); end
        n = 0;
        while (!done && n < 30) begin tick(); n++; end
        tick();
        checks++; if (cur_tap !== 5'd20) begin errors++; $display("FAIL held_cur_tap: got %0d want 20", cur_tap); end
    endtask

    task automatic test_rdy_loss();
        int n, dones;
        req_valid = 1'b1; req_op = 2'b00; req_tap = 5'd22;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        rdy = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rdy_loss_flags: err=%0b done=%0b busy=%0b ready=%0b want 1/0/1/0", err, done, busy, req_ready); end
        tick();
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || err !== 1'b0 || cur_tap !== 5'd20) begin
            errors++; $display("FAIL rdy_loss_wait: busy=%0b ready=%0b err=%0b tap=%0d want 1/0/0/20", busy, req_ready, err, cur_tap); end
        tick();
        rdy = 1'b1;
        tick();
        checks++; if (idly_ld !== 1'b1 || idly_cntvaluein !== 5'd0) begin
            errors++; $display("FAIL reinit_ld: ld=%0b val=%0d want 1/0", idly_ld, idly_cntvaluein); end
        n = 0; dones = 0;
        while (!req_ready && n < 30) begin tick(); n++; if (done) dones++; end
        checks++; if (n !== S + 2 || dones !== 0) begin
            errors++; $display("FAIL reinit_ready: cycles=%0d done=%0d want %0d/0", n, dones, S + 2); end
        checks++; if (cur_tap !== 5'd0) begin errors++; $display("FAIL reinit_tap: got %0d want 0", cur_tap); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_load();
        test_inc_sat();
        test_dec();
        test_reserved();
        test_mismatch();
        test_back_to_back();
        test_rdy_loss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
